// File: rtl/pc_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel and the
// valid/ready channel that hands fetched words to decode.
// The master modport is the fetch stage; the slave modport is the
// memory/decode side.
interface pc_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        output inst_o,
        output inst_valid_o,
        input  imem_ack_i,
        input  imem_data_i,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        input  inst_o,
        input  inst_valid_o,
        output imem_ack_i,
        output imem_data_i,
        output inst_ready_i
    );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch stage.
// Holds the PC, requests each instruction over a req/ack memory handshake,
// and hands the registered word to decode over valid/ready with a stall.
// Optional feature macro: PC_FETCH_TIMEOUT_EN adds a REQ watchdog that
// raises a sticky fetch_err_o and abandons the fetch after TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | no request outstanding, waiting for start_i
// REQ   | imem_req_o high, address held stable until imem_ack_i
// VALID | inst_valid_o high, inst_o/pc_o held until accepted
module pc_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       pc_next_i,
    input  logic              stall_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic              fetch_err_o,
    pc_fetch_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("pc_fetch: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        req_q;
    logic        valid_q;
    logic        start_ok;
    logic        accept;

    // The low PC bits are dropped at load, so they are never consumed.
    logic        unused_pc_low;
    assign unused_pc_low = &{1'b0, pc_next_i[1:0]};

    assign accept = (state == VALID) && bus.inst_ready_i && !stall_i;

`ifdef PC_FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_cnt;
    logic       err_q;

    // A latched fetch error locks the stage in IDLE until reset.
    assign start_ok    = start_i && !err_q;
    assign fetch_err_o = err_q;
`else
    assign start_ok    = start_i;
    assign fetch_err_o = 1'b0;
`endif

    // Fetch sequencer: state, PC, instruction register and handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
            timeout_cnt <= 8'h0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= REQ;
                        req_q <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
                        timeout_cnt <= 8'h0;
`endif
                    end
                end
                REQ: begin
                    if (bus.imem_ack_i) begin
                        inst_q  <= bus.imem_data_i;
                        state   <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
`ifdef PC_FETCH_TIMEOUT_EN
                    else if (timeout_cnt == TIMEOUT_LAST) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                        req_q <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
`endif
                end
                VALID: begin
                    if (accept) begin
                        pc_q    <= {pc_next_i[31:2], 2'b00};
                        valid_q <= 1'b0;
                        if (start_ok) begin
                            state <= REQ;
                            req_q <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
                            timeout_cnt <= 8'h0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o             = pc_q;
    assign pc_plus4_o       = pc_q + 32'd4;
    assign bus.imem_addr_o  = pc_q;
    assign bus.imem_req_o   = req_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: a table of per-cycle {inputs, expected outputs}
// records replayed through a scoreboard queue, followed by hand-written
// reset-in-REQ and fetch-timeout sequences.
module tb_pc_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_next_i;
    logic        stall_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_err_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_i = ~clk_i;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC      (32'h0000_0100),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .pc_next_i  (pc_next_i),
        .stall_i    (stall_i),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .fetch_err_o(fetch_err_o),
        .bus        (bus)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic        stall;
        logic [31:0] pc_next;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic start, input logic ack,
                                input logic [31:0] data, input logic ready, input logic stall,
                                input logic [31:0] pc_next, input logic e_req,
                                input logic [31:0] e_pc, input logic e_valid,
                                input logic [31:0] e_inst, input logic e_err);
        vec_t v;
        v.rst = rst;   v.start = start; v.ack = ack;     v.data = data;
        v.ready = ready; v.stall = stall; v.pc_next = pc_next;
        v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst_i           = v.rst;
        start_i         = v.start;
        bus.imem_ack_i  = v.ack;
        bus.imem_data_i = v.data;
        bus.inst_ready_i = v.ready;
        stall_i         = v.stall;
        pc_next_i       = v.pc_next;
        e.req = v.e_req; e.pc = v.e_pc; e.valid = v.e_valid;
        e.inst = v.e_inst; e.err = v.e_err;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk("imem_req",   idx, {31'h0, bus.imem_req_o},   {31'h0, e.req});
        chk("imem_addr",  idx, bus.imem_addr_o,           e.pc);
        chk("pc",         idx, pc_o,                      e.pc);
        chk("pc_plus4",   idx, pc_plus4_o,                e.pc + 32'd4);
        chk("inst_valid", idx, {31'h0, bus.inst_valid_o}, {31'h0, e.valid});
        chk("inst",       idx, bus.inst_o,                e.inst);
        chk("fetch_err",  idx, {31'h0, fetch_err_o},      {31'h0, e.err});
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; pc_next_i = 32'h0; stall_i = 1'b0;
        bus.imem_ack_i = 1'b0; bus.imem_data_i = 32'h0; bus.inst_ready_i = 1'b0;

        //          rst start ack data          rdy stl pc_next        req pc            vld inst          err
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h0,         0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         0));
        vecs.push_back(mk(0, 1, 1, 32'h8C01_0004, 1, 0, 32'h104,       0, 32'h0000_0100, 1, 32'h8C01_0004, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h104,       1, 32'h0000_0104, 0, 32'h8C01_0004, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 0, 32'h8C01_0004, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 0, 32'h8C01_0004, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 0, 32'h8C01_0004, 0));
        vecs.push_back(mk(0, 1, 1, 32'h1234_5678, 1, 0, 32'hDEAD_BEEF, 0, 32'h0000_0104, 1, 32'h1234_5678, 0));
        vecs.push_back(mk(0, 1, 1, 32'hFFFF_0000, 1, 1, 32'h203,       0, 32'h0000_0104, 1, 32'h1234_5678, 0));
        vecs.push_back(mk(0, 1, 1, 32'hFFFF_0000, 1, 1, 32'h203,       0, 32'h0000_0104, 1, 32'h1234_5678, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h203,       1, 32'h0000_0200, 0, 32'h1234_5678, 0));
        vecs.push_back(mk(0, 1, 1, 32'hAAAA_5555, 0, 0, 32'h0,         0, 32'h0000_0200, 1, 32'hAAAA_5555, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h300,       0, 32'h0000_0200, 1, 32'hAAAA_5555, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0, 32'hAAAA_5555, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0BAD_0BAD, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0BAD_0BAD, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h400,       0, 32'h0000_0400, 0, 32'h0BAD_0BAD, 0));
        vecs.push_back(mk(0, 0, 1, 32'h1111_1111, 1, 0, 32'h500,       0, 32'h0000_0400, 0, 32'h0BAD_0BAD, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // PC wrap boundary: 0xFFFF_FFFC + 4 must read back as zero.
        @(negedge clk_i);
        chk("wrap_direct", 900, {31'h0, (32'hFFFF_FFFC + 32'd4) == 32'h0}, 32'h1);

        // Reset while a request is outstanding; the following ack must be ignored.
        apply(mk(0, 1, 0, 32'h0,         0, 0, 32'h0, 1, 32'h0000_0400, 0, 32'h0BAD_0BAD, 0), 100);
        apply(mk(1, 1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0000_0100, 0, 32'h0,         0), 101);
        apply(mk(0, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h0, 0, 32'h0000_0100, 0, 32'h0,         0), 102);
        apply(mk(0, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h0, 0, 32'h0000_0100, 0, 32'h0,         0), 103);

        // Memory that never acks.
        apply(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0100, 0, 32'h0, 0), 200);
        for (int i = 0; i < 15; i++)
            apply(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0100, 0, 32'h0, 0), 201 + i);
`ifdef PC_FETCH_TIMEOUT_EN
        apply(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0000_0100, 0, 32'h0, 1), 216);
        for (int i = 0; i < 3; i++)
            apply(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0000_0100, 0, 32'h0, 1), 217 + i);
        apply(mk(1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0000_0100, 0, 32'h0, 0), 220);
        apply(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0100, 0, 32'h0, 0), 221);
`else
        for (int i = 0; i < 10; i++)
            apply(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0000_0100, 0, 32'h0, 0), 216 + i);
`endif
        apply(mk(0, 1, 1, 32'h5A5A_A5A5, 0, 0, 32'h0, 0, 32'h0000_0100, 1, 32'h5A5A_A5A5, 0), 230);
        apply(mk(0, 0, 0, 32'h0,         1, 0, 32'h8, 0, 32'h0000_0008, 0, 32'h5A5A_A5A5, 0), 231);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
